elevator_ctrl: RTL and testbench
================================

ELEVATOR_CTRL -- requirements
Module: elevator_ctrl

Interface
REQ-001 Parameter NUM_FLOORS, default 4, number of served floors (2..16).
REQ-002 Parameter FLOOR_TICKS, default 2000000, clk cycles of motor run per one-floor travel.
REQ-003 Parameter DOOR_TICKS, default 50000000, clk cycles the door stays open.
REQ-004 Parameter FW, default 2, width of floor index, SHALL satisfy 2^FW >= NUM_FLOORS.
REQ-005 clk  input  1  system clock; one clock domain, all logic on rising edge.
REQ-006 reset_n  input  1  asynchronous active-low reset.
REQ-007 req  input  NUM_FLOORS  floor call strobes; bit i high for >=1 cycle requests floor i.
REQ-008 estop  input  1  emergency stop, active-high level.
REQ-009 motor_onoff  output  1  run enable to stepper driver.
REQ-010 motor_dir  output  1  1 = up, 0 = down; meaningful only while motor_onoff=1.
REQ-011 cur_floor  output  FW  floor index the car is at or last passed.
REQ-012 door_open  output  1  door open indicator.
REQ-013 pending  output  NUM_FLOORS  latched outstanding calls.
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 States SHALL be IDLE, MOVE_UP, MOVE_DN, DOOR; all outputs registered.
REQ-016 pending[i] SHALL set on the cycle after req[i]=1; it SHALL clear only when floor i is serviced (REQ-019/REQ-021); set has priority over clear on the same cycle, except for the floor being serviced in DOOR (REQ-022).
REQ-017 last_dir register, reset 1 (up), SHALL record direction of the most recent move.
REQ-018 IDLE decision, one cycle: pending[cur_floor] -> DOOR; else calls both above and below -> move in last_dir; else only above -> MOVE_UP; else only below -> MOVE_DN; else stay IDLE.
REQ-019 Entering DOOR SHALL clear pending[cur_floor], load door timer to DOOR_TICKS-1, assert door_open next cycle.
REQ-020 MOVE_UP/MOVE_DN: motor_onoff=1, motor_dir=1/0, travel counter counts 0..FLOOR_TICKS-1; at terminal count cur_floor SHALL increment/decrement by exactly 1 and counter SHALL wrap to 0.
REQ-021 At floor arrival: pending[new floor] -> DOOR with motor_onoff=0 the same edge; else further calls in travel direction -> keep moving, counter restarts; else -> IDLE.
REQ-022 In DOOR, a new req for cur_floor SHALL reload the door timer and SHALL NOT set pending; on timer expiry -> IDLE, door_open=0.
REQ-023 cur_floor SHALL never go below 0 nor above NUM_FLOORS-1; MOVE_UP SHALL not be entered at top floor nor MOVE_DN at floor 0.
REQ-024 estop=1 SHALL force motor_onoff=0 within one cycle and freeze travel counter, door timer and state; pending still latches new req; on estop=0 operation resumes from frozen values.
REQ-025 motor_onoff SHALL never be 1 while door_open=1.
REQ-026 motor_dir SHALL not change while motor_onoff=1.

Reset
REQ-027 reset_n=0 SHALL asynchronously force state IDLE, cur_floor=0, pending=0, motor_onoff=0, motor_dir=0, door_open=0, busy=0, counters=0, last_dir=1.
REQ-028 Reset mid-travel or mid-door SHALL discard all calls; no output SHALL glitch high during or in the first cycle after reset release.

Verification (FLOOR_TICKS=10, DOOR_TICKS=5, NUM_FLOORS=4)
REQ-029 Reset, pulse req=0100 -> MOVE_UP, motor_onoff=1, motor_dir=1 for 20 cycles, cur_floor 0->1->2, then door_open=1 for 5 cycles, pending=0000, IDLE.
REQ-030 At floor 1 moving up with pending=1001 -> continues to floor 3, door, then reverses to floor 0; last_dir=0 at end.
REQ-031 req=0001 while in IDLE at floor 0 -> DOOR next cycle, no motor activity, pending bit never observed 1 after entering DOOR.
REQ-032 estop=1 for 7 cycles mid-travel -> motor_onoff=0 next cycle, counter frozen; arrival delayed exactly 7 cycles after release.
REQ-033 Re-press current floor on door cycle 3 -> door_open stays high 5 further cycles; pending unchanged.
REQ-034 reset_n low mid-travel at floor 2 -> all outputs zero immediately, cur_floor=0, pending=0000 after release.

Source files
------------

// File: rtl/elevator_ctrl.sv
// Elevator car controller: latches floor calls, serves them with a direction-preference
// scan, runs the motor one floor per FLOOR_TICKS and holds the door for DOOR_TICKS.
module elevator_ctrl #(
  parameter int NUM_FLOORS  = 4,
  parameter int FLOOR_TICKS = 2000000,
  parameter int DOOR_TICKS  = 50000000,
  parameter int FW          = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_FLOORS-1:0] req,
  input  logic                  estop,
  output logic                  motor_onoff,
  output logic                  motor_dir,
  output logic [FW-1:0]         cur_floor,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  busy
);
  localparam int TW = $clog2(FLOOR_TICKS + 1);
  localparam int DW = $clog2(DOOR_TICKS + 1);

  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DN, DOOR} state_t;

  state_t          state;
  logic [TW-1:0]   travel_cnt;
  logic [DW-1:0]   door_cnt;
  logic            last_dir;

  logic [FW-1:0]         nf;
  logic [NUM_FLOORS-1:0] cur_oh, nf_oh, gt_cur, lt_cur, gt_nf, lt_nf;
  logic [NUM_FLOORS-1:0] clr, mask, pend_nxt;
  logic                  tc, have_here, have_above, have_below;
  logic                  idle_go, idle_dir, arrive_hit, more;

  always_comb begin
    tc  = (travel_cnt == TW'(FLOOR_TICKS - 1));
    nf  = (state == MOVE_UP) ? cur_floor + FW'(1) : cur_floor - FW'(1);
    cur_oh = '0; nf_oh = '0; gt_cur = '0; lt_cur = '0; gt_nf = '0; lt_nf = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      cur_oh[i] = (cur_floor == FW'(i));
      nf_oh[i]  = (nf == FW'(i));
      gt_cur[i] = (FW'(i) > cur_floor);
      lt_cur[i] = (FW'(i) < cur_floor);
      gt_nf[i]  = (FW'(i) > nf);
      lt_nf[i]  = (FW'(i) < nf);
    end
    have_here  = |(pending & cur_oh);
    have_above = |(pending & gt_cur);
    have_below = |(pending & lt_cur);
    idle_go    = have_above | have_below;
    idle_dir   = (have_above && have_below) ? last_dir : have_above;
    arrive_hit = |(pending & nf_oh);
    more       = (state == MOVE_UP) ? |(pending & gt_nf) : |(pending & lt_nf);

    // Only the floor actually being serviced is cleared; frozen under estop.
    clr = '0;
    if (!estop) begin
      if (state == IDLE && have_here) clr = cur_oh;
      else if ((state == MOVE_UP || state == MOVE_DN) && tc && arrive_hit) clr = nf_oh;
    end
    // Calls for the floor whose door is (or is becoming) open are absorbed, not latched.
    mask     = clr | ((state == DOOR) ? cur_oh : '0);
    pend_nxt = (pending | (req & ~mask)) & ~clr;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cur_floor   <= '0;
      pending     <= '0;
      motor_onoff <= 1'b0;
      motor_dir   <= 1'b0;
      door_open   <= 1'b0;
      busy        <= 1'b0;
      travel_cnt  <= '0;
      door_cnt    <= '0;
      last_dir    <= 1'b1;
    end else begin
      pending <= pend_nxt;
      if (estop) begin
        motor_onoff <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (have_here) begin
              state     <= DOOR;
              door_cnt  <= DW'(DOOR_TICKS - 1);
              door_open <= 1'b1;
              busy      <= 1'b1;
            end else if (idle_go) begin
              state       <= idle_dir ? MOVE_UP : MOVE_DN;
              motor_onoff <= 1'b1;
              motor_dir   <= idle_dir;
              last_dir    <= idle_dir;
              travel_cnt  <= '0;
              busy        <= 1'b1;
            end
          end
          MOVE_UP, MOVE_DN: begin
            motor_onoff <= 1'b1;
            if (tc) begin
              travel_cnt <= '0;
              cur_floor  <= nf;
              if (arrive_hit) begin
                state       <= DOOR;
                motor_onoff <= 1'b0;
                door_open   <= 1'b1;
                door_cnt    <= DW'(DOOR_TICKS - 1);
              end else if (!more) begin
                state       <= IDLE;
                motor_onoff <= 1'b0;
                busy        <= 1'b0;
              end
            end else begin
              travel_cnt <= travel_cnt + TW'(1);
            end
          end
          DOOR: begin
            if (|(req & cur_oh)) begin
              door_cnt <= DW'(DOOR_TICKS - 1);
            end else if (door_cnt == '0) begin
              state     <= IDLE;
              door_open <= 1'b0;
              busy      <= 1'b0;
            end else begin
              door_cnt <= door_cnt - DW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_elevator_ctrl.sv
// Directed bench for elevator_ctrl with short travel/door times.
module tb_elevator_ctrl;
  logic       clk, reset_n, estop;
  logic [3:0] req;
  logic       motor_onoff, motor_dir, door_open, busy;
  logic [1:0] cur_floor;
  logic [3:0] pending;

  int total = 0, passed = 0, viol = 0, n;
  logic prev_on = 1'b0, prev_dir = 1'b0;

  elevator_ctrl #(.NUM_FLOORS(4), .FLOOR_TICKS(10), .DOOR_TICKS(5), .FW(2)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .estop(estop),
    .motor_onoff(motor_onoff), .motor_dir(motor_dir), .cur_floor(cur_floor),
    .door_open(door_open), .pending(pending), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic       motor;
    logic [1:0] floor;
    logic       door;
    logic [3:0] pend;
    logic       busy;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else passed++;
  endtask

  task automatic step();
    @(posedge clk); #1;
    if (motor_onoff && door_open) viol++;
    if (prev_on && motor_onoff && motor_dir != prev_dir) viol++;
    prev_on = motor_onoff; prev_dir = motor_dir;
  endtask

  task automatic wait_door(input logic lvl, input int maxc, output int cnt);
    cnt = 0;
    while (door_open !== lvl && cnt < maxc) begin step(); cnt++; end
  endtask

  task automatic wait_floor(input logic [1:0] f, input int maxc, output int cnt);
    cnt = 0;
    while (cur_floor !== f && cnt < maxc) begin step(); cnt++; end
  endtask

  initial begin
    tbl[0] = '{4'b0001, 0, 0, 0, 4'b0001, 0};
    tbl[1] = '{4'b0000, 0, 0, 1, 4'b0000, 1};
    tbl[2] = '{4'b0001, 0, 0, 1, 4'b0000, 1};
    tbl[3] = '{4'b0000, 0, 0, 1, 4'b0000, 1};
    tbl[4] = '{4'b0000, 0, 0, 1, 4'b0000, 1};
    tbl[5] = '{4'b0000, 0, 0, 1, 4'b0000, 1};
    tbl[6] = '{4'b0000, 0, 0, 1, 4'b0000, 1};
    tbl[7] = '{4'b0000, 0, 0, 0, 4'b0000, 0};

    // Reset with calls asserted: nothing latches.
    reset_n = 1'b0; estop = 1'b0; req = 4'b1111;
    step(); step();
    chk("rst.motor", motor_onoff, 0); chk("rst.dir", motor_dir, 0);
    chk("rst.floor", cur_floor, 0);   chk("rst.door", door_open, 0);
    chk("rst.pend", pending, 0);      chk("rst.busy", busy, 0);
    req = 4'b0000; #2 reset_n = 1'b1;
    step();
    chk("rel.pend", pending, 0); chk("rel.busy", busy, 0); chk("rel.motor", motor_onoff, 0);

    // Current-floor call and door re-press.
    for (int i = 0; i < 8; i++) begin
      req = tbl[i].req;
      step();
      chk($sformatf("vec%0d.motor", i), motor_onoff, tbl[i].motor);
      chk($sformatf("vec%0d.floor", i), cur_floor, tbl[i].floor);
      chk($sformatf("vec%0d.door", i), door_open, tbl[i].door);
      chk($sformatf("vec%0d.pend", i), pending, tbl[i].pend);
      chk($sformatf("vec%0d.busy", i), busy, tbl[i].busy);
    end
    req = 4'b0000;

    // Two-floor trip up to floor 2.
    req = 4'b0100; step(); req = 4'b0000;
    chk("up.pend", pending, 4'b0100);
    step();
    chk("up.motor", motor_onoff, 1); chk("up.dir", motor_dir, 1); chk("up.busy", busy, 1);
    repeat (9) step();
    chk("up.f0", cur_floor, 0); chk("up.m0", motor_onoff, 1);
    step();
    chk("up.f1", cur_floor, 1);
    repeat (9) step();
    chk("up.m1", motor_onoff, 1);
    step();
    chk("up.f2", cur_floor, 2); chk("up.arr_motor", motor_onoff, 0);
    chk("up.arr_door", door_open, 1); chk("up.arr_pend", pending, 0);
    wait_door(1'b0, 20, n);
    chk("up.door_len", n, 5); chk("up.idle_busy", busy, 0);

    // Fresh start: serve 3 then reverse to 0.
    reset_n = 1'b0; step(); reset_n = 1'b1; step();
    chk("rev.rst_floor", cur_floor, 0);
    req = 4'b1000; step(); req = 4'b0000;
    step();
    chk("rev.motor", motor_onoff, 1);
    req = 4'b0001; step(); req = 4'b0000;
    chk("rev.pend", pending, 4'b1001);
    wait_floor(2'd1, 20, n);
    chk("rev.to_f1", n, 9); chk("rev.f1_motor", motor_onoff, 1); chk("rev.f1_pend", pending, 4'b1001);
    wait_door(1'b1, 40, n);
    chk("rev.to_door3", n, 20); chk("rev.f3", cur_floor, 3); chk("rev.p3", pending, 4'b0001);
    wait_door(1'b0, 20, n);
    chk("rev.door_len", n, 5);
    step();
    chk("rev.dn_motor", motor_onoff, 1); chk("rev.dn_dir", motor_dir, 0);
    wait_door(1'b1, 60, n);
    chk("rev.to_door0", n, 30); chk("rev.f0", cur_floor, 0); chk("rev.p0", pending, 0);
    wait_door(1'b0, 20, n);
    chk("rev.door0_len", n, 5);

    // Emergency stop for 7 cycles mid-travel.
    req = 4'b0010; step(); req = 4'b0000;
    step();
    chk("es.motor", motor_onoff, 1);
    repeat (3) step();
    estop = 1'b1; req = 4'b1000; step(); req = 4'b0000;
    chk("es.off", motor_onoff, 0); chk("es.latch", pending, 4'b1010);
    repeat (6) step();
    chk("es.still_off", motor_onoff, 0); chk("es.floor", cur_floor, 0);
    estop = 1'b0; step();
    chk("es.resume", motor_onoff, 1);
    wait_door(1'b1, 40, n);
    chk("es.arrive", n, 6); chk("es.f1", cur_floor, 1); chk("es.pend", pending, 4'b1000);
    wait_door(1'b0, 20, n);

    // Asynchronous reset mid-travel at floor 2.
    wait_floor(2'd2, 40, n);
    chk("ar.at_f2", cur_floor, 2); chk("ar.moving", motor_onoff, 1);
    reset_n = 1'b0; #1;
    chk("ar.motor", motor_onoff, 0); chk("ar.dir", motor_dir, 0);
    chk("ar.floor", cur_floor, 0);   chk("ar.pend", pending, 0);
    chk("ar.busy", busy, 0);         chk("ar.door", door_open, 0);
    #2 reset_n = 1'b1;
    step();
    chk("ar.rel_floor", cur_floor, 0); chk("ar.rel_pend", pending, 0);
    chk("ar.rel_motor", motor_onoff, 0); chk("ar.rel_busy", busy, 0);

    chk("invariants", viol, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
